// File: rtl/sr_cmd_gen.sv
// Synchronises and debounces two raw request lines and turns each clean press into a
// single-cycle, mutually exclusive set/reset pulse for a downstream SR flip-flop.
module sr_cmd_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_set,
    input  logic btn_reset,
    output logic set,
    output logic reset,
    output logic conflict,
    output logic locked
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        StIdle,
        StLockout
    } state_e;

    // Channel 0 is the set request, channel 1 the reset request.
    logic [1:0]            raw;
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            stable_q, stable_d, stable_dly_q;
    logic [1:0]            rise;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

    state_e state_q, state_d;
    logic   set_q, set_d;
    logic   reset_q, reset_d;
    logic   conflict_q, conflict_d;

    assign raw = {btn_reset, btn_set};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
        end
    end

    // Counter only runs while the synchronised input disagrees, so it never exceeds CntMax.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise = stable_q & ~stable_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            set_q      <= 1'b0;
            reset_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            set_q      <= set_d;
            reset_q    <= reset_d;
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        set_d      = 1'b0;
        reset_d    = 1'b0;
        conflict_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A rise while the other channel is already held is treated like a tie.
                if ((rise[0] && rise[1]) || (rise[0] && stable_q[1]) ||
                    (rise[1] && stable_q[0])) begin
                    conflict_d = 1'b1;
                    state_d    = StLockout;
                end else begin
                    set_d   = rise[0];
                    reset_d = rise[1];
                end
            end
            StLockout: begin
                if (stable_q == 2'b00) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign set      = set_q;
    assign reset    = reset_q;
    assign conflict = conflict_q;
    assign locked   = (state_q == StLockout);

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Randomised and directed bench for sr_cmd_gen, checked cycle by cycle against a
// history-based reference model of the debounce/pulse rules.
module tb_sr_cmd_gen;

    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_set = 1'b0;
    logic btn_reset = 1'b0;
    logic set, reset, conflict, locked;

    sr_cmd_gen #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_set(btn_set),
        .btn_reset(btn_reset),
        .set(set),
        .reset(reset),
        .conflict(conflict),
        .locked(locked)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: hs/hr hold the most recent raw samples (index 0 newest).
    // A debounced value flips once the synchronised samples it sees have all
    // disagreed with it for D consecutive edges.
    logic hs[0:D];
    logic hr[0:D];
    logic st_s, st_r, st_s_old, st_r_old;
    logic m_lock, m_set, m_reset, m_conf;

    task automatic model_reset();
        for (int i = 0; i <= D; i++) begin
            hs[i] = 1'b0;
            hr[i] = 1'b0;
        end
        st_s = 0; st_r = 0; st_s_old = 0; st_r_old = 0;
        m_lock = 0; m_set = 0; m_reset = 0; m_conf = 0;
    endtask

    task automatic model_edge(input logic bs, input logic br);
        logic rs, rr;
        bit all_s, all_r;
        rs = st_s & ~st_s_old;
        rr = st_r & ~st_r_old;
        m_set = 0; m_reset = 0; m_conf = 0;
        if (!m_lock) begin
            if ((rs && rr) || (rs && st_r) || (rr && st_s)) begin
                m_conf = 1;
                m_lock = 1;
            end else begin
                m_set = rs;
                m_reset = rr;
            end
        end else if (!st_s && !st_r) begin
            m_lock = 0;
        end
        all_s = 1;
        all_r = 1;
        // Two flops of synchronisation: this edge sees the samples at hist[1..D].
        for (int i = 1; i <= D; i++) begin
            if (hs[i] == st_s) all_s = 0;
            if (hr[i] == st_r) all_r = 0;
        end
        st_s_old = st_s;
        st_r_old = st_r;
        if (all_s) st_s = ~st_s;
        if (all_r) st_r = ~st_r;
        for (int i = D; i >= 1; i--) begin
            hs[i] = hs[i-1];
            hr[i] = hr[i-1];
        end
        hs[0] = bs;
        hr[0] = br;
    endtask

    // Observation bookkeeping for directed timing checks.
    int tick_idx, cnt_set, cnt_reset, cnt_conf, first_set, first_reset, first_conf;

    task automatic clear_obs();
        tick_idx = 0; cnt_set = 0; cnt_reset = 0; cnt_conf = 0;
        first_set = 0; first_reset = 0; first_conf = 0;
    endtask

    task automatic tick(input logic bs, input logic br);
        btn_set = bs;
        btn_reset = br;
        @(posedge clk);
        model_edge(bs, br);
        @(negedge clk);
        tick_idx++;
        check_eq("set", int'(set), int'(m_set));
        check_eq("reset", int'(reset), int'(m_reset));
        check_eq("conflict", int'(conflict), int'(m_conf));
        check_eq("locked", int'(locked), int'(m_lock));
        check_eq("set_reset_excl", int'(set & reset), 0);
        if (set === 1'b1) begin
            cnt_set++;
            if (first_set == 0) first_set = tick_idx;
        end
        if (reset === 1'b1) begin
            cnt_reset++;
            if (first_reset == 0) first_reset = tick_idx;
        end
        if (conflict === 1'b1) begin
            cnt_conf++;
            if (first_conf == 0) first_conf = tick_idx;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    // Called just after a negedge; pulses reset asynchronously and releases before the posedge.
    task automatic async_reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq({tag, "_set"}, int'(set), 0);
        check_eq({tag, "_reset"}, int'(reset), 0);
        check_eq({tag, "_conflict"}, int'(conflict), 0);
        check_eq({tag, "_locked"}, int'(locked), 0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int drop;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_set", int'(set), 0);
        check_eq("rst_reset", int'(reset), 0);
        check_eq("rst_conflict", int'(conflict), 0);
        check_eq("rst_locked", int'(locked), 0);
        #1 rst_n = 1'b1;

        // Clean press on set.
        clear_obs();
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
        idle(12);
        check_eq("clean_set_edge", first_set, 7);
        check_eq("clean_set_count", cnt_set, 1);
        check_eq("clean_reset_count", cnt_reset, 0);
        check_eq("clean_conf_count", cnt_conf, 0);

        // Bounce rejection, then a real hold on reset.
        clear_obs();
        for (int i = 0; i < 12; i++) tick(((i / 2) % 2) == 0, 1'b0 ^ 1'b0 | (((i / 2) % 2) == 0));
        idle(8);
        check_eq("bounce_any_pulse", cnt_set + cnt_reset + cnt_conf, 0);
        clear_obs();
        for (int i = 0; i < 15; i++) tick(1'b0, 1'b1);
        idle(12);
        check_eq("hold_reset_edge", first_reset, 7);
        check_eq("hold_reset_count", cnt_reset, 1);

        // Simultaneous press.
        clear_obs();
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1);
        check_eq("simul_conf_edge", first_conf, 7);
        check_eq("simul_conf_count", cnt_conf, 1);
        check_eq("simul_pulses", cnt_set + cnt_reset, 0);
        check_eq("simul_locked", int'(locked), 1);
        drop = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b0, 1'b0);
            if (drop == 0 && locked === 1'b0) drop = i;
        end
        check_eq("simul_unlock_edge", drop, 7);

        // Overlap: set held, reset joins, reset leaves first.
        clear_obs();
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < 15; i++) tick(1'b1, 1'b0);
        check_eq("overlap_set_count", cnt_set, 1);
        check_eq("overlap_conf_count", cnt_conf, 1);
        check_eq("overlap_still_locked", int'(locked), 1);
        idle(12);

        // Async reset while set is high.
        clear_obs();
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b0);
        check_eq("pre_rst_set", int'(set), 1);
        async_reset_pulse("midpulse");
        clear_obs();
        for (int i = 0; i < 14; i++) tick(1'b1, 1'b0);
        check_eq("post_rst_set_edge", first_set, 7);
        check_eq("post_rst_set_count", cnt_set, 1);
        idle(12);

        // Back-to-back set then reset.
        clear_obs();
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
        idle(10);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
        idle(10);
        check_eq("b2b_set_count", cnt_set, 1);
        check_eq("b2b_reset_count", cnt_reset, 1);
        check_eq("b2b_order", int'(first_set < first_reset), 1);
        check_eq("b2b_conf_count", cnt_conf, 0);

        // Randomised hold patterns with occasional async resets.
        for (int k = 0; k < 300; k++) begin
            logic [1:0] pat;
            int len;
            pat = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) tick(pat[0], pat[1]);
            if ($urandom_range(0, 29) == 0) async_reset_pulse("rand_rst");
        end
        idle(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
